vxe_txnid_router: RTL and testbench
===================================

Name: vxe_txnid_router

Overview:
- Registered transaction-ID tracker and response router between the memory-fabric response port and the VxEngine clients (CU, VPU0, VPU1).
- Field layout of the ID is parametrised.
- Keeps a scoreboard of outstanding IDs, set by request issue and cleared by response retirement.
- Decodes each response ID and forwards the data to the owning client through a one-deep registered valid/ready stage. Flags protocol errors.

Parameters:
- CLIENT_BITS, 2, width of client-id field (MSBs of ID)
- THREAD_BITS, 3, width of thread-id field (middle)
- ARG_BITS, 1, width of argument field (LSBs)
- NCLIENTS, 3, number of client ports; must be ≤ 2**CLIENT_BITS
- DATA_WIDTH, 64, response data width
- Derived (localparam): IDW = CLIENT_BITS+THREAD_BITS+ARG_BITS; NIDS = 2**IDW

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_req_vld  in  1  request valid on fabric issue port (snooped)
- i_req_rdy  in  1  fabric ready on issue port (snooped)
- i_req_txnid  in  IDW  ID of issued request
- i_rsp_vld  in  1  response valid from fabric
- o_rsp_rdy  out  1  response accepted
- i_rsp_txnid  in  IDW  response ID
- i_rsp_data  in  DATA_WIDTH  response data
- o_cl_vld  out  NCLIENTS  per-client response valid (one-hot or zero)
- i_cl_rdy  in  NCLIENTS  per-client ready
- o_cl_data  out  DATA_WIDTH  response data, shared by all clients
- o_cl_thread  out  THREAD_BITS  decoded thread id
- o_cl_arg  out  ARG_BITS  decoded argument field
- o_outstanding  out  IDW+1  count of outstanding IDs
- o_err_unexp  out  1  sticky: unexpected response
- o_err_dup  out  1  sticky: duplicate issue
- i_err_clr  in  1  clears both sticky error flags

Behaviour:
- Reset (nrst low, async):
  - scoreboard all 0
  - o_cl_vld=0; o_cl_data/thread/arg=0
  - o_outstanding=0; o_err_unexp=0; o_err_dup=0
  - Reset mid-operation discards the held response and all tracking.
- Decode: client = ID[IDW-1 -: CLIENT_BITS]; thread = next THREAD_BITS; arg = ID[ARG_BITS-1:0]. This matches the current 2/3/1 layout at the defaults.
- Issue: when i_req_vld & i_req_rdy, set sb[i_req_txnid].
  - If the bit is already set and not being cleared this cycle: o_err_dup ← 1 (bit stays set).
- Response accept: rsp_acc = i_rsp_vld & o_rsp_rdy.
  - o_rsp_rdy = ~out_vld | (i_cl_rdy & o_cl_vld) != 0. This is combinational pass-through, so back-to-back responses run at full rate.
- Valid response: sb[id] set and client < NCLIENTS.
  - On accept: clear sb[id]; load the output stage; in the next cycle o_cl_vld[client]=1 with data/thread/arg. Latency is 1 cycle.
- Invalid response: sb clear, or client ≥ NCLIENTS.
  - Still accepted and dropped (no o_cl_vld); o_err_unexp ← 1; scoreboard unchanged.
- Output stage: holds stable while o_cl_vld is set and the selected i_cl_rdy=0. It clears when the client accepts and no new valid response is accepted in the same cycle.
- Issue and response with the same ID in the same cycle: the clear is applied first, then the set. The bit ends set, the response routes normally, no error.
- o_outstanding: +1 on a non-duplicate issue; −1 on a valid response. Both in the same cycle gives net 0. It never wraps: the maximum is NIDS and duplicates do not count.
- Sticky errors: hold until i_err_clr. If i_err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Ready ignored on idle client ports; i_cl_rdy of non-selected clients has no effect.

Decomposition:
- Package vxe_txnid_pkg:
  - default field widths, the CU/VPU0/VPU1 client-id constants, and the ID-packing/unpacking functions
  - shared with the encoder side so that layouts cannot diverge
- One sub-module: vxe_txnid_scoreboard.
  - Contains the NIDS-bit set/clear vector, the outstanding counter and the dup detection.
  - Interface: set port, clear port, hit-lookup output.
- Routing and the output register stay in the top.

Test Plan:
- Issue IDs 0x12 and 0x25; response 0x25 with data 0xA5 → next cycle o_cl_vld=3'b100? No: client 2 (VPU1) gives o_cl_vld=3'b100, thread=2, arg=1, data=0xA5. o_outstanding goes 2→1.
- Response 0x12 while i_cl_rdy[1]=0 for 3 cycles → o_cl_vld=3'b010 held stable with thread=1, arg=0; o_rsp_rdy=0; a second pending response is not accepted until ready rises.
- Response 0x07 with no prior issue → accepted, no o_cl_vld, o_err_unexp=1; i_err_clr pulse → 0.
- Issue 0x30 (client 3 ≥ NCLIENTS); response 0x30 → dropped, o_err_unexp=1, sb[0x30] remains set, o_outstanding=1.
- Issue 0x11 twice without a response → o_err_dup=1, o_outstanding=1. Same-cycle response 0x11 plus issue 0x11 → routed, bit still set, no new error.
- Assert nrst low while o_cl_vld=3'b001 and 5 IDs outstanding → immediately o_cl_vld=0 and o_outstanding=0; a later response for any of those IDs raises o_err_unexp.

Source files
------------

// File: rtl/vxe_txnid_pkg.sv
// Shared transaction-ID layout for the VxEngine fabric. The encoder side and
// the response router both import this so the field layout is defined once.
package vxe_txnid_pkg;

  localparam int CLIENT_BITS_DEF = 2;
  localparam int THREAD_BITS_DEF = 3;
  localparam int ARG_BITS_DEF    = 1;
  localparam int NCLIENTS_DEF    = 3;
  localparam int DATA_WIDTH_DEF  = 64;
  localparam int IDW_DEF         = CLIENT_BITS_DEF + THREAD_BITS_DEF + ARG_BITS_DEF;

  // Client-id values carried in the ID MSBs.
  typedef enum logic [CLIENT_BITS_DEF-1:0] {
    CLIENT_CU   = 2'd0,
    CLIENT_VPU0 = 2'd1,
    CLIENT_VPU1 = 2'd2
  } client_e;

  typedef logic [IDW_DEF-1:0] txnid_t;

  // Field order is MSB first, so the packed struct is the ID bit layout.
  typedef struct packed {
    logic [CLIENT_BITS_DEF-1:0] client;
    logic [THREAD_BITS_DEF-1:0] thread;
    logic [ARG_BITS_DEF-1:0]    arg;
  } txnid_fields_t;

  function automatic txnid_t txnid_pack(input txnid_fields_t f);
    return txnid_t'(f);
  endfunction

  function automatic txnid_fields_t txnid_unpack(input txnid_t id);
    return txnid_fields_t'(id);
  endfunction

endpackage

// File: rtl/vxe_txnid_scoreboard.sv
// Outstanding-ID tracker: one bit per ID, set on issue, cleared on retirement,
// plus a saturating-free outstanding count and duplicate-issue detection.
module vxe_txnid_scoreboard #(
  parameter int IDW = vxe_txnid_pkg::IDW_DEF
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           i_set_vld,
  input  logic [IDW-1:0] i_set_id,
  input  logic           i_clr_vld,
  input  logic [IDW-1:0] i_clr_id,
  input  logic [IDW-1:0] i_lkp_id,
  output logic           o_lkp_hit,
  output logic           o_dup,
  output logic [IDW:0]   o_outstanding
);

  localparam int NIDS = 2 ** IDW;

  logic [NIDS-1:0] sb_q, sb_d;
  logic [IDW:0]    cnt_q, cnt_d;
  logic            set_new;

  assign o_lkp_hit     = sb_q[i_lkp_id];
  assign o_outstanding = cnt_q;

  // A set is a duplicate only if the bit survives this cycle's clear.
  assign o_dup   = i_set_vld & sb_q[i_set_id] & ~(i_clr_vld & (i_clr_id == i_set_id));
  assign set_new = i_set_vld & ~o_dup;

  // Next-state: clear first, then set, so a same-cycle retire+reissue ends set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sb_d  = sb_q;
    cnt_d = cnt_q;
    if (i_clr_vld) sb_d[i_clr_id] = 1'b0;
    if (i_set_vld) sb_d[i_set_id] = 1'b1;
    // Only new IDs count, so the count is bounded by NIDS and cannot wrap.
    cnt_d = cnt_q + (IDW+1)'(set_new) - (IDW+1)'(i_clr_vld);
  end

  // State registers; the vector is small enough to be plain reset flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vxe_txnid_router.sv
// Response router: decodes fabric response IDs against the outstanding-ID
// scoreboard and forwards valid responses to the owning client through a
// one-deep registered valid/ready stage. Unexpected and duplicate IDs are
// reported on sticky error flags.
module vxe_txnid_router
  import vxe_txnid_pkg::*;
#(
  parameter  int CLIENT_BITS = CLIENT_BITS_DEF,
  parameter  int THREAD_BITS = THREAD_BITS_DEF,
  parameter  int ARG_BITS    = ARG_BITS_DEF,
  parameter  int NCLIENTS    = NCLIENTS_DEF,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  localparam int IDW         = CLIENT_BITS + THREAD_BITS + ARG_BITS
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_req_vld,
  input  logic                   i_req_rdy,
  input  logic [IDW-1:0]         i_req_txnid,
  input  logic                   i_rsp_vld,
  output logic                   o_rsp_rdy,
  input  logic [IDW-1:0]         i_rsp_txnid,
  input  logic [DATA_WIDTH-1:0]  i_rsp_data,
  output logic [NCLIENTS-1:0]    o_cl_vld,
  input  logic [NCLIENTS-1:0]    i_cl_rdy,
  output logic [DATA_WIDTH-1:0]  o_cl_data,
  output logic [THREAD_BITS-1:0] o_cl_thread,
  output logic [ARG_BITS-1:0]    o_cl_arg,
  output logic [IDW:0]           o_outstanding,
  output logic                   o_err_unexp,
  output logic                   o_err_dup,
  input  logic                   i_err_clr
);

  logic [NCLIENTS-1:0]    cl_vld_q, cl_vld_d;
  logic [DATA_WIDTH-1:0]  cl_data_q, cl_data_d;
  logic [THREAD_BITS-1:0] cl_thread_q, cl_thread_d;
  logic [ARG_BITS-1:0]    cl_arg_q, cl_arg_d;
  logic                   err_unexp_q, err_unexp_d;
  logic                   err_dup_q, err_dup_d;

  logic [CLIENT_BITS-1:0] rsp_client;
  logic                   rsp_hit, rsp_ok, rsp_acc, rsp_route, out_take, dup;

  // ID decode: client in the MSBs, thread in the middle, argument in the LSBs.
  assign rsp_client = i_rsp_txnid[IDW-1 -: CLIENT_BITS];

  // The output slot is free when empty or when its selected client takes it
  // this cycle, which lets responses stream at one per cycle.
  assign out_take  = |(i_cl_rdy & cl_vld_q);
  assign o_rsp_rdy = ~(|cl_vld_q) | out_take;
  assign rsp_acc   = i_rsp_vld & o_rsp_rdy;
  assign rsp_ok    = rsp_hit & ({1'b0, rsp_client} < (CLIENT_BITS+1)'(NCLIENTS));
  assign rsp_route = rsp_acc & rsp_ok;

  vxe_txnid_scoreboard #(.IDW(IDW)) u_sb (
    .clk           (clk),
    .nrst          (nrst),
    .i_set_vld     (i_req_vld & i_req_rdy),
    .i_set_id      (i_req_txnid),
    .i_clr_vld     (rsp_route),
    .i_clr_id      (i_rsp_txnid),
    .i_lkp_id      (i_rsp_txnid),
    .o_lkp_hit     (rsp_hit),
    .o_dup         (dup),
    .o_outstanding (o_outstanding)
  );

  // Output stage and sticky-error next state; a new error beats a clear.
  always_comb begin
    cl_vld_d    = cl_vld_q;
    cl_data_d   = cl_data_q;
    cl_thread_d = cl_thread_q;
    cl_arg_d    = cl_arg_q;
    if (rsp_route) begin
      cl_vld_d    = NCLIENTS'(1) << rsp_client;
      cl_data_d   = i_rsp_data;
      cl_thread_d = i_rsp_txnid[ARG_BITS +: THREAD_BITS];
      cl_arg_d    = i_rsp_txnid[ARG_BITS-1:0];
    end else if (out_take) begin
      cl_vld_d    = '0;
    end
    err_unexp_d = (err_unexp_q & ~i_err_clr) | (rsp_acc & ~rsp_ok);
    err_dup_d   = (err_dup_q & ~i_err_clr) | dup;
  end

  // Output and error registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cl_vld_q    <= '0;
      cl_data_q   <= '0;
      cl_thread_q <= '0;
      cl_arg_q    <= '0;
      err_unexp_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      cl_vld_q    <= cl_vld_d;
      cl_data_q   <= cl_data_d;
      cl_thread_q <= cl_thread_d;
      cl_arg_q    <= cl_arg_d;
      err_unexp_q <= err_unexp_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign o_cl_vld    = cl_vld_q;
  assign o_cl_data   = cl_data_q;
  assign o_cl_thread = cl_thread_q;
  assign o_cl_arg    = cl_arg_q;
  assign o_err_unexp = err_unexp_q;
  assign o_err_dup   = err_dup_q;

endmodule

// File: tb/tb_vxe_txnid_router.sv
// Bench for vxe_txnid_router at default parameters: a reference model of the
// outstanding set predicts routing, expected deliveries are queued at accept
// and popped by a monitor on each client handshake.
module tb_vxe_txnid_router;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req_vld, i_req_rdy;
  logic [5:0]  i_req_txnid;
  logic        i_rsp_vld;
  logic        o_rsp_rdy;
  logic [5:0]  i_rsp_txnid;
  logic [63:0] i_rsp_data;
  logic [2:0]  o_cl_vld;
  logic [2:0]  i_cl_rdy;
  logic [63:0] o_cl_data;
  logic [2:0]  o_cl_thread;
  logic [0:0]  o_cl_arg;
  logic [6:0]  o_outstanding;
  logic        o_err_unexp, o_err_dup, i_err_clr;

  typedef struct {
    logic [2:0]  vld;
    logic [63:0] data;
    logic [2:0]  thread;
    logic        arg;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_sb;
  int          exp_cnt;
  logic        exp_unexp, exp_dup;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  vxe_txnid_router dut (
    .clk(clk), .nrst(nrst),
    .i_req_vld(i_req_vld), .i_req_rdy(i_req_rdy), .i_req_txnid(i_req_txnid),
    .i_rsp_vld(i_rsp_vld), .o_rsp_rdy(o_rsp_rdy), .i_rsp_txnid(i_rsp_txnid),
    .i_rsp_data(i_rsp_data), .o_cl_vld(o_cl_vld), .i_cl_rdy(i_cl_rdy),
    .o_cl_data(o_cl_data), .o_cl_thread(o_cl_thread), .o_cl_arg(o_cl_arg),
    .o_outstanding(o_outstanding), .o_err_unexp(o_err_unexp),
    .o_err_dup(o_err_dup), .i_err_clr(i_err_clr)
  );

  // Monitor: every client handshake must match the oldest expected delivery.
  always @(negedge clk) begin
    if (nrst && (o_cl_vld & i_cl_rdy) != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deliver_unexpected got vld=%b data=%h", o_cl_vld, o_cl_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_cl_vld !== e.vld || o_cl_data !== e.data ||
            o_cl_thread !== e.thread || o_cl_arg !== e.arg) begin
          errors++;
          $display("FAIL deliver got vld=%b data=%h thr=%0d arg=%0d want vld=%b data=%h thr=%0d arg=%0d",
                   o_cl_vld, o_cl_data, o_cl_thread, o_cl_arg,
                   e.vld, e.data, e.thread, e.arg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_sb    = '0;
    exp_cnt   = 0;
    exp_unexp = 1'b0;
    exp_dup   = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus with the model updated as the spec describes:
  // response retirement first, then issue, then sticky-error update.
  task automatic cycle(input bit rq, input logic [5:0] rid, input bit rs,
                       input logic [5:0] sid, input logic [63:0] data,
                       input bit clr);
    bit   new_unexp, new_dup;
    exp_t e;
    new_unexp = 1'b0;
    new_dup   = 1'b0;
    if (rs) begin
      if (exp_sb[sid] && sid[5:4] < 2'd3) begin
        e.vld = 3'b001 << sid[5:4];
        e.data = data;
        e.thread = sid[3:1];
        e.arg = sid[0];
        exp_q.push_back(e);
        exp_sb[sid] = 1'b0;
        exp_cnt--;
      end else begin
        new_unexp = 1'b1;
      end
    end
    if (rq) begin
      if (exp_sb[rid]) new_dup = 1'b1;
      else begin
        exp_sb[rid] = 1'b1;
        exp_cnt++;
      end
    end
    exp_unexp = (exp_unexp && !clr) || new_unexp;
    exp_dup   = (exp_dup && !clr) || new_dup;
    i_req_vld = rq; i_req_rdy = rq; i_req_txnid = rid;
    i_rsp_vld = rs; i_rsp_txnid = sid; i_rsp_data = data;
    i_err_clr = clr;
    tick();
    i_req_vld = 1'b0; i_req_rdy = 1'b0; i_rsp_vld = 1'b0; i_err_clr = 1'b0;
  endtask

  task automatic wait_rsp_rdy();
    int w = 0;
    while (!o_rsp_rdy && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (o_rsp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rsp_rdy_timeout got %b want 1", o_rsp_rdy);
    end
  endtask

  task automatic issue(input logic [5:0] id);
    cycle(1'b1, id, 1'b0, 6'd0, 64'd0, 1'b0);
  endtask

  task automatic respond(input logic [5:0] id, input logic [63:0] data);
    wait_rsp_rdy();
    cycle(1'b0, 6'd0, 1'b1, id, data, 1'b0);
  endtask

  task automatic check_status(input string tag);
    checks++;
    if (o_outstanding !== 7'(exp_cnt) || o_err_unexp !== exp_unexp || o_err_dup !== exp_dup) begin
      errors++;
      $display("FAIL %s status got cnt=%0d unexp=%b dup=%b want cnt=%0d unexp=%b dup=%b",
               tag, o_outstanding, o_err_unexp, o_err_dup, exp_cnt, exp_unexp, exp_dup);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o_cl_vld !== 3'b000 || o_cl_data !== 64'd0 || o_cl_thread !== 3'd0 ||
        o_cl_arg !== 1'b0 || o_rsp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b data=%h thr=%0d arg=%0d rdy=%b want 0/0/0/0/1",
               o_cl_vld, o_cl_data, o_cl_thread, o_cl_arg, o_rsp_rdy);
    end
    check_status("reset");
  endtask

  task automatic test_route();
    issue(6'h12);
    issue(6'h25);
    check_status("route_issue");
    respond(6'h25, 64'hA5);
    checks++;
    if (o_cl_vld !== 3'b100 || o_cl_thread !== 3'd2 || o_cl_arg !== 1'b1 || o_cl_data !== 64'hA5) begin
      errors++;
      $display("FAIL route_0x25 got vld=%b thr=%0d arg=%0d data=%h want 100/2/1/a5",
               o_cl_vld, o_cl_thread, o_cl_arg, o_cl_data);
    end
    check_status("route_rsp");
  endtask

  task automatic test_backpressure();
    exp_t e;
    issue(6'h04);
    i_cl_rdy = 3'b101;
    respond(6'h12, 64'h5A);
    i_rsp_vld = 1'b1; i_rsp_txnid = 6'h04; i_rsp_data = 64'hC0DE;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_cl_vld !== 3'b010 || o_cl_thread !== 3'd1 || o_cl_arg !== 1'b0 ||
          o_cl_data !== 64'h5A || o_rsp_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got vld=%b thr=%0d arg=%0d data=%h rdy=%b want 010/1/0/5a/0",
                 i, o_cl_vld, o_cl_thread, o_cl_arg, o_cl_data, o_rsp_rdy);
      end
      tick();
    end
    // Ready rises: the held response leaves and 0x04 is accepted on the same edge.
    e.vld = 3'b001; e.data = 64'hC0DE; e.thread = 3'd2; e.arg = 1'b0;
    exp_q.push_back(e);
    exp_sb[6'h04] = 1'b0;
    exp_cnt--;
    i_cl_rdy = 3'b111;
    tick();
    i_rsp_vld = 1'b0;
    checks++;
    if (o_cl_vld !== 3'b001 || o_cl_data !== 64'hC0DE) begin
      errors++;
      $display("FAIL back_to_back got vld=%b data=%h want 001/c0de", o_cl_vld, o_cl_data);
    end
    check_status("backpressure");
  endtask

  task automatic test_unexpected();
    respond(6'h07, 64'h77);
    checks++;
    if (o_cl_vld !== 3'b000) begin
      errors++;
      $display("FAIL unexp_drop got vld=%b want 000", o_cl_vld);
    end
    check_status("unexp_set");
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 64'd0, 1'b1);
    check_status("unexp_clr");
    // Clear and a new error in the same cycle: the error wins.
    wait_rsp_rdy();
    cycle(1'b0, 6'd0, 1'b1, 6'h07, 64'h1, 1'b1);
    check_status("unexp_clr_vs_err");
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 64'd0, 1'b1);
  endtask

  task automatic test_bad_client();
    issue(6'h30);
    respond(6'h30, 64'h30);
    checks++;
    if (o_cl_vld !== 3'b000) begin
      errors++;
      $display("FAIL bad_client_drop got vld=%b want 000", o_cl_vld);
    end
    check_status("bad_client");
    // The bit must still be set, so a reissue is a duplicate.
    issue(6'h30);
    check_status("bad_client_still_set");
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 64'd0, 1'b1);
  endtask

  task automatic test_dup();
    issue(6'h11);
    issue(6'h11);
    check_status("dup_issue");
    cycle(1'b0, 6'd0, 1'b0, 6'd0, 64'd0, 1'b1);
    wait_rsp_rdy();
    cycle(1'b1, 6'h11, 1'b1, 6'h11, 64'h1111, 1'b0);
    checks++;
    if (o_cl_vld !== 3'b010 || o_cl_thread !== 3'd0 || o_cl_arg !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_route got vld=%b thr=%0d arg=%0d want 010/0/1",
               o_cl_vld, o_cl_thread, o_cl_arg);
    end
    check_status("same_cycle");
    respond(6'h11, 64'h2222);
    check_status("same_cycle_reissued");
  endtask

  task automatic test_reset_mid();
    issue(6'h01); issue(6'h02); issue(6'h03); issue(6'h08); issue(6'h09);
    i_cl_rdy = 3'b110;
    respond(6'h01, 64'hDEAD);
    checks++;
    if (o_cl_vld !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset_hold got vld=%b want 001", o_cl_vld);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (o_cl_vld !== 3'b000 || o_outstanding !== 7'd0 || o_cl_data !== 64'd0) begin
      errors++;
      $display("FAIL async_reset got vld=%b cnt=%0d data=%h want 000/0/0",
               o_cl_vld, o_outstanding, o_cl_data);
    end
    model_reset();
    #3 nrst = 1'b1;
    i_cl_rdy = 3'b111;
    tick();
    respond(6'h02, 64'h2);
    checks++;
    if (o_cl_vld !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_drop got vld=%b want 000", o_cl_vld);
    end
    check_status("post_reset");
  endtask

  initial begin
    nrst = 1'b0;
    i_req_vld = 1'b0; i_req_rdy = 1'b0; i_req_txnid = '0;
    i_rsp_vld = 1'b0; i_rsp_txnid = '0; i_rsp_data = '0;
    i_cl_rdy = 3'b111; i_err_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    nrst = 1'b1;
    tick();
    test_reset();
    test_route();
    test_backpressure();
    test_unexpected();
    test_bad_client();
    test_dup();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undelivered got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
